// File: rtl/eth_rx_fcs_checker.sv
// -----------------------------------------------------------------------------
// eth_rx_fcs_checker
//
// Receive-side Ethernet FCS checker. Bytes arrive from the MAC with the
// 4-byte FCS still attached. Every accepted byte goes through a CRC-32 engine
// and into a 4-byte delay line. A payload byte leaves the delay line only once
// four newer bytes have arrived behind it, so the trailing four bytes (the FCS)
// are still held in the delay line when tlast arrives and are simply dropped.
// The last payload byte carries the frame verdict on m_axis_tuser.
//
// Handshake (both ports): a beat transfers on a rising clk edge where
// tvalid & tready are both 1. The output register holds data, tlast and tuser
// stable while m_axis_tvalid & !m_axis_trdy. The input is ready whenever the
// output register is empty or is being drained in the same cycle.
//
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   s_axis_tdata/tvalid/tlast/tuser   input stream from MAC (tuser = PHY error)
//   s_axis_trdy                input ready
//   m_axis_tdata/tvalid/tlast/tuser   payload stream, FCS stripped
//                              (tuser = bad frame, valid with tlast only)
//   m_axis_trdy                downstream ready
//   o_good_frame, o_bad_fcs, o_bad_len   single-cycle status pulses
//   dbg_state_o                current FSM state (IDLE=0, FILL=1, STREAM=2)
// -----------------------------------------------------------------------------
module eth_rx_fcs_checker #(
    parameter int MIN_FRAME_LEN = 64,
    parameter int MAX_FRAME_LEN = 1518
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] s_axis_tdata,
    input  logic       s_axis_tvalid,
    input  logic       s_axis_tlast,
    input  logic       s_axis_tuser,
    output logic       s_axis_trdy,
    output logic [7:0] m_axis_tdata,
    output logic       m_axis_tvalid,
    output logic       m_axis_tlast,
    output logic       m_axis_tuser,
    input  logic       m_axis_trdy,
    output logic       o_good_frame,
    output logic       o_bad_fcs,
    output logic       o_bad_len,
    output logic [1:0] dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        STREAM = 2'd2
    } state_t;

    localparam logic [15:0] MIN_LEN16 = 16'(MIN_FRAME_LEN);
    localparam logic [15:0] MAX_LEN16 = 16'(MAX_FRAME_LEN);
    localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;

    // One byte of the reflected CRC-32 (poly 0x04C11DB7 reflected = 0xEDB88320),
    // data consumed LSB first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc_in,
                                               input logic [7:0]  data);
        logic [31:0] c;
        c = crc_in;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data[i]) c = (c >> 1) ^ 32'hEDB8_8320;
            else                c = c >> 1;
        end
        return c;
    endfunction

    state_t          state_q, state_d;
    logic [3:0][7:0] dl_q, dl_d;       // dl_q[0] is the oldest byte
    logic [15:0]     cnt_q, cnt_d;
    logic [31:0]     crc_q, crc_d;
    logic            err_q, err_d;
    logic [7:0]      m_data_q, m_data_d;
    logic            m_valid_q, m_valid_d;
    logic            m_last_q, m_last_d;
    logic            m_user_q, m_user_d;
    logic            good_q, good_d;
    logic            bad_fcs_q, bad_fcs_d;
    logic            bad_len_q, bad_len_d;

    logic            accept;
    logic            frame_start;
    logic [15:0]     cnt_prev, cnt_new;
    logic [31:0]     crc_new;
    logic            err_new;
    logic            dl_full;
    logic            fcs_bad, len_err, frame_bad;

    assign s_axis_trdy = !m_valid_q || m_axis_trdy;
    assign accept      = s_axis_tvalid && s_axis_trdy;

    // In IDLE the per-frame state is treated as freshly initialised, so the
    // first byte of a frame never sees leftovers from the previous one and a
    // new frame can follow a tlast beat with no gap cycle.
    assign frame_start = (state_q == IDLE);
    assign cnt_prev    = frame_start ? 16'd0 : cnt_q;
    assign cnt_new     = (&cnt_prev) ? cnt_prev : cnt_prev + 16'd1;
    assign crc_new     = crc32_byte(frame_start ? CRC_INIT : crc_q, s_axis_tdata);
    assign err_new     = (frame_start ? 1'b0 : err_q) | s_axis_tuser;
    // Four bytes already held: the oldest one is a payload byte.
    assign dl_full     = |cnt_prev[15:2];
    assign fcs_bad     = (crc_new != CRC_RESIDUE);
    assign len_err     = (cnt_new < MIN_LEN16) || (cnt_new > MAX_LEN16);
    assign frame_bad   = dl_full ? (fcs_bad | len_err | err_new) : 1'b1;

    always_comb begin
        state_d   = state_q;
        dl_d      = dl_q;
        cnt_d     = cnt_q;
        crc_d     = crc_q;
        err_d     = err_q;
        m_data_d  = m_data_q;
        m_valid_d = m_valid_q && !m_axis_trdy;
        m_last_d  = m_last_q;
        m_user_d  = m_user_q;
        good_d    = 1'b0;
        bad_fcs_d = 1'b0;
        bad_len_d = 1'b0;

        if (accept) begin
            dl_d  = {s_axis_tdata, dl_q[3:1]};
            cnt_d = cnt_new;
            crc_d = crc_new;
            err_d = err_new;

            if (s_axis_tlast) begin
                state_d   = IDLE;
                cnt_d     = 16'd0;
                m_valid_d = 1'b1;
                m_last_d  = 1'b1;
                m_user_d  = frame_bad;
                // Frames too short to contain any payload still get one
                // terminating beat so downstream sees the frame end.
                m_data_d  = dl_full ? dl_q[0] : 8'h00;
                good_d    = !frame_bad;
                bad_fcs_d = fcs_bad;
                bad_len_d = len_err;
            end else begin
                state_d = (cnt_new > 16'd3) ? STREAM : FILL;
                if (dl_full) begin
                    m_valid_d = 1'b1;
                    m_last_d  = 1'b0;
                    m_user_d  = 1'b0;
                    m_data_d  = dl_q[0];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            dl_q      <= '0;
            cnt_q     <= 16'd0;
            crc_q     <= CRC_INIT;
            err_q     <= 1'b0;
            m_data_q  <= 8'h00;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            m_user_q  <= 1'b0;
            good_q    <= 1'b0;
            bad_fcs_q <= 1'b0;
            bad_len_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            dl_q      <= dl_d;
            cnt_q     <= cnt_d;
            crc_q     <= crc_d;
            err_q     <= err_d;
            m_data_q  <= m_data_d;
            m_valid_q <= m_valid_d;
            m_last_q  <= m_last_d;
            m_user_q  <= m_user_d;
            good_q    <= good_d;
            bad_fcs_q <= bad_fcs_d;
            bad_len_q <= bad_len_d;
        end
    end

    assign m_axis_tdata  = m_data_q;
    assign m_axis_tvalid = m_valid_q;
    assign m_axis_tlast  = m_last_q;
    assign m_axis_tuser  = m_user_q;
    assign o_good_frame  = good_q;
    assign o_bad_fcs     = bad_fcs_q;
    assign o_bad_len     = bad_len_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_eth_rx_fcs_checker.sv
// -----------------------------------------------------------------------------
// tb_eth_rx_fcs_checker
//
// Directed frames built by the bench (random payload, FCS appended by a
// reference CRC routine, optional deliberate corruption). Expected output
// beats are {tuser, tlast, tdata}: payload bytes 0..len-5, verdict on the
// last one. Each test task drives, drains and compares inline.
// -----------------------------------------------------------------------------
module tb_eth_rx_fcs_checker;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] s_axis_tdata = 8'h00;
    logic       s_axis_tvalid = 1'b0;
    logic       s_axis_tlast = 1'b0;
    logic       s_axis_tuser = 1'b0;
    logic       s_axis_trdy;
    logic [7:0] m_axis_tdata;
    logic       m_axis_tvalid;
    logic       m_axis_tlast;
    logic       m_axis_tuser;
    logic       m_axis_trdy = 1'b1;
    logic       o_good_frame;
    logic       o_bad_fcs;
    logic       o_bad_len;
    logic [1:0] dbg_state;

    int errors = 0;
    int checks = 0;
    int good_cnt = 0;
    int bad_fcs_cnt = 0;
    int bad_len_cnt = 0;

    logic [7:0] tx_q[$];
    logic [9:0] exp_q[$];
    logic [9:0] got_q[$];

    eth_rx_fcs_checker #(.MIN_FRAME_LEN(64), .MAX_FRAME_LEN(1518)) dut (
        .clk           (clk),
        .reset         (reset),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_trdy   (s_axis_trdy),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_trdy   (m_axis_trdy),
        .o_good_frame  (o_good_frame),
        .o_bad_fcs     (o_bad_fcs),
        .o_bad_len     (o_bad_len),
        .dbg_state_o   (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- output monitor ----------------
    logic       stall_prev = 1'b0;
    logic [9:0] held_beat = '0;

    always @(negedge clk) begin
        if (reset) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                checks++;
                if (!m_axis_tvalid || {m_axis_tuser, m_axis_tlast, m_axis_tdata} !== held_beat) begin
                    errors++;
                    $display("FAIL stall_hold: got valid=%0b beat=%h required valid=1 beat=%h",
                             m_axis_tvalid, {m_axis_tuser, m_axis_tlast, m_axis_tdata}, held_beat);
                end
            end
            if (m_axis_tvalid && m_axis_trdy)
                got_q.push_back({m_axis_tuser, m_axis_tlast, m_axis_tdata});
            if (o_good_frame) good_cnt++;
            if (o_bad_fcs)    bad_fcs_cnt++;
            if (o_bad_len)    bad_len_cnt++;
            stall_prev = m_axis_tvalid && !m_axis_trdy;
            held_beat  = {m_axis_tuser, m_axis_tlast, m_axis_tdata};
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int k = 0; k < 8; k++)
            r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        return r;
    endfunction

    task automatic build_frame(input int len, input bit corrupt);
        logic [31:0] c;
        logic [7:0]  b;
        tx_q.delete();
        c = 32'hFFFF_FFFF;
        if (len <= 4) begin
            for (int i = 0; i < len; i++) tx_q.push_back(8'($urandom_range(0, 255)));
        end else begin
            for (int i = 0; i < len - 4; i++) begin
                b = 8'($urandom_range(0, 255));
                tx_q.push_back(b);
                c = crc_step(c, b);
            end
            c = ~c;
            tx_q.push_back(c[7:0]);
            tx_q.push_back(c[15:8]);
            tx_q.push_back(c[23:16]);
            tx_q.push_back(c[31:24]);
            if (corrupt) tx_q[len-4] = tx_q[len-4] ^ 8'h01;
        end
    endtask

    task automatic expect_frame(input int len, input bit bad);
        if (len >= 5) begin
            for (int i = 0; i < len - 4; i++)
                exp_q.push_back({(i == len - 5) ? bad : 1'b0, (i == len - 5), tx_q[i]});
        end else begin
            exp_q.push_back({1'b1, 1'b1, 8'h00});
        end
    endtask

    // Entered and left just after a rising edge. Drives bytes 0..n-1 of tx_q;
    // tlast marks byte len-1. Leaves the last byte on the bus so a following
    // frame can start with no gap.
    task automatic drive_frame(input int n, input int len, input int err_idx, input bit rnd);
        int i = 0;
        int guard = 0;
        while (i < n) begin
            m_axis_trdy   = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            s_axis_tvalid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            s_axis_tdata  = tx_q[i];
            s_axis_tlast  = (i == len - 1);
            s_axis_tuser  = (i == err_idx);
            @(negedge clk);
            if (s_axis_tvalid && s_axis_trdy) i++;
            guard++;
            @(posedge clk); #1;
            if (guard > 40 * n + 100) begin
                checks++;
                errors++;
                $display("FAIL drive_timeout: accepted %0d bytes, required %0d", i, n);
                break;
            end
        end
    endtask

    task automatic drain();
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = 1'b0;
        m_axis_trdy   = 1'b1;
        repeat (10) @(posedge clk);
        #1;
    endtask

    task automatic clear_sb();
        exp_q.delete();
        got_q.delete();
        good_cnt = 0;
        bad_fcs_cnt = 0;
        bad_len_cnt = 0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        @(negedge clk);
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b required 0", m_axis_tvalid); end
        checks++; if (m_axis_tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast: got %b required 0", m_axis_tlast); end
        checks++; if (m_axis_tuser !== 1'b0) begin errors++; $display("FAIL reset_tuser: got %b required 0", m_axis_tuser); end
        checks++; if (m_axis_tdata !== 8'h00) begin errors++; $display("FAIL reset_tdata: got %h required 00", m_axis_tdata); end
        checks++; if ({o_good_frame, o_bad_fcs, o_bad_len} !== 3'b000) begin errors++; $display("FAIL reset_status: got %b required 000", {o_good_frame, o_bad_fcs, o_bad_len}); end
        checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d required 0", dbg_state); end
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checks++; if (s_axis_trdy !== 1'b1) begin errors++; $display("FAIL reset_trdy: got %b required 1", s_axis_trdy); end
        @(posedge clk); #1;
    endtask

    task automatic run_single(input string name, input int len, input bit corrupt,
                              input int err_idx, input bit bad,
                              input int exp_good, input int exp_bfcs, input int exp_blen,
                              input bit chk_fcs);
        clear_sb();
        build_frame(len, corrupt);
        expect_frame(len, bad);
        drive_frame(len, len, err_idx, 1'b0);
        drain();
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL %s beat_count: got %0d required %0d", name, got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL %s beat[%0d]: got %h required %h", name, i, got_q[i], exp_q[i]);
            end
        end
        checks++; if (good_cnt != exp_good) begin errors++; $display("FAIL %s good_pulses: got %0d required %0d", name, good_cnt, exp_good); end
        checks++; if (bad_len_cnt != exp_blen) begin errors++; $display("FAIL %s bad_len_pulses: got %0d required %0d", name, bad_len_cnt, exp_blen); end
        if (chk_fcs) begin
            checks++; if (bad_fcs_cnt != exp_bfcs) begin errors++; $display("FAIL %s bad_fcs_pulses: got %0d required %0d", name, bad_fcs_cnt, exp_bfcs); end
        end
    endtask

    task automatic test_good_frame();
        run_single("good64", 64, 1'b0, -1, 1'b0, 1, 0, 0, 1'b1);
    endtask

    task automatic test_bad_fcs();
        run_single("badfcs64", 64, 1'b1, -1, 1'b1, 0, 1, 0, 1'b1);
    endtask

    task automatic test_short_frame();
        run_single("short3", 3, 1'b0, -1, 1'b1, 0, 0, 1, 1'b0);
        run_single("short5", 5, 1'b0, -1, 1'b1, 0, 0, 1, 1'b1);
    endtask

    task automatic test_length_limits();
        run_single("max1518", 1518, 1'b0, -1, 1'b0, 1, 0, 0, 1'b1);
        run_single("long1519", 1519, 1'b0, -1, 1'b1, 0, 0, 1, 1'b1);
        run_single("len63", 63, 1'b0, -1, 1'b1, 0, 0, 1, 1'b1);
    endtask

    task automatic test_phy_error();
        run_single("phyerr64", 64, 1'b0, 10, 1'b1, 0, 0, 0, 1'b1);
    endtask

    task automatic test_back_to_back();
        int lens[6]  = '{64, 70, 3, 65, 64, 100};
        bit cor[6]   = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        int perr[6]  = '{-1, -1, -1, 20, -1, -1};
        int exp_good = 0;
        int exp_blen = 0;
        bit bad;
        clear_sb();
        for (int f = 0; f < 6; f++) begin
            bad = cor[f] || (lens[f] < 64) || (lens[f] > 1518) || (perr[f] >= 0);
            if (!bad) exp_good++;
            if (lens[f] < 64 || lens[f] > 1518) exp_blen++;
            build_frame(lens[f], cor[f]);
            expect_frame(lens[f], bad);
            drive_frame(lens[f], lens[f], perr[f], 1'b1);
        end
        drain();
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL b2b beat_count: got %0d required %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL b2b beat[%0d]: got %h required %h", i, got_q[i], exp_q[i]);
            end
        end
        checks++; if (good_cnt != exp_good) begin errors++; $display("FAIL b2b good_pulses: got %0d required %0d", good_cnt, exp_good); end
        checks++; if (bad_len_cnt != exp_blen) begin errors++; $display("FAIL b2b bad_len_pulses: got %0d required %0d", bad_len_cnt, exp_blen); end
    endtask

    task automatic test_reset_mid_frame();
        int tl = 0;
        clear_sb();
        build_frame(64, 1'b0);
        drive_frame(30, 64, -1, 1'b0);
        s_axis_tvalid = 1'b0;
        @(negedge clk);
        checks++; if (dbg_state !== 2'd2) begin errors++; $display("FAIL midrst_state_before: got %0d required 2", dbg_state); end
        reset = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL midrst_state_after: got %0d required 0", dbg_state); end
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL midrst_tvalid: got %b required 0", m_axis_tvalid); end
        @(posedge clk); #1;
        drain();
        foreach (got_q[i]) if (got_q[i][8]) tl++;
        checks++; if (tl != 0) begin errors++; $display("FAIL midrst_partial_tlast: got %0d tlast beats required 0", tl); end
        checks++; if (good_cnt + bad_fcs_cnt + bad_len_cnt != 0) begin errors++; $display("FAIL midrst_pulses: got %0d required 0", good_cnt + bad_fcs_cnt + bad_len_cnt); end
        run_single("after_rst64", 64, 1'b0, -1, 1'b0, 1, 0, 0, 1'b1);
    endtask

    // ---------------- sequence ----------------
    initial begin
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_good_frame();
        test_bad_fcs();
        test_short_frame();
        test_length_limits();
        test_phy_error();
        test_back_to_back();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
